// File: rtl/a51_wb_pkg.sv
// Shared constants and state type for the A5/1 Wishbone initiator.
// Register offsets are relative to the peripheral base address.
package a51_wb_pkg;

    localparam logic [31:0] OFS_CTRL   = 32'h00;
    localparam logic [31:0] OFS_STATUS = 32'h04;
    localparam logic [31:0] OFS_KEY_LO = 32'h08;
    localparam logic [31:0] OFS_KEY_HI = 32'h0C;
    localparam logic [31:0] OFS_FRAME  = 32'h10;
    localparam logic [31:0] OFS_KS     = 32'h14;

    localparam int STATUS_READY_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_KLO,
        ST_WR_KHI,
        ST_WR_FRM,
        ST_WR_GO,
        ST_POLL,
        ST_RD_KS,
        ST_PUSH
    } state_t;

endpackage

// File: rtl/wb_master_port.sv
// Single Wishbone classic transaction engine. Optional ack watchdog is built
// only when A51_MASTER_TIMEOUT_EN is defined.
module wb_master_port #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_done,
    output logic        o_timeout,
    output logic [31:0] o_rdata,
    output logic        o_cyc,
    output logic        o_stb,
    output logic        o_we,
    output logic [3:0]  o_sel,
    output logic [31:0] o_adr,
    output logic [31:0] o_dat,
    input  logic        i_ack,
    input  logic [31:0] i_dat
);

    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        w_start;
    logic        w_ack;
    logic        w_timeout;

    // A request is only taken while idle; the ack edge never restarts, which
    // guarantees an idle cycle between back-to-back transactions.
    assign w_start = i_req && !r_cyc;
    assign w_ack   = r_cyc && i_ack;

`ifdef A51_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (srst || w_start) begin
            r_tmo_cnt <= '0;
        end else if (r_cyc) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_timeout = r_cyc && !i_ack && (r_tmo_cnt == TMO_LAST);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (w_start) begin
            r_cyc <= 1'b1;
            r_we  <= i_we;
            r_adr <= i_addr;
            r_dat <= i_wdata;
        end else if (w_ack || w_timeout) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end
    end

    assign o_done    = w_ack;
    assign o_timeout = w_timeout;
    assign o_rdata   = i_dat;
    assign o_cyc     = r_cyc;
    assign o_stb     = r_cyc;
    assign o_we      = r_we;
    assign o_sel     = r_cyc ? 4'hF : 4'h0;
    assign o_adr     = r_adr;
    assign o_dat     = r_dat;

endmodule

// File: rtl/a51_wb_master.sv
// Session sequencer driving the A5/1 peripheral over Wishbone and streaming
// keystream words out. A51_MASTER_TIMEOUT_EN enables the ack watchdog and err.
module a51_wb_master
    import a51_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int unsigned WORDS          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_key,
    input  logic [21:0] cmd_frame,
    output logic        ks_valid,
    input  logic        ks_ready,
    output logic [31:0] ks_data,
    output logic        ks_last,
    output logic        busy,
    output logic        err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_key;
    logic [21:0] r_frame;
    logic [3:0]  r_word_cnt;
    logic [31:0] r_ks_data;
    logic        w_req;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_rdata;
    logic        w_last;

    assign w_last = (r_word_cnt == LAST_WORD);

    wb_master_port #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_port (
        .clk      (wb_clk_i),
        .srst     (wb_rst_i),
        .i_req    (w_req),
        .i_we     (w_we),
        .i_addr   (w_addr),
        .i_wdata  (w_wdata),
        .o_done   (w_done),
        .o_timeout(w_timeout),
        .o_rdata  (w_rdata),
        .o_cyc    (wbm_cyc_o),
        .o_stb    (wbm_stb_o),
        .o_we     (wbm_we_o),
        .o_sel    (wbm_sel_o),
        .o_adr    (wbm_adr_o),
        .o_dat    (wbm_dat_o),
        .i_ack    (wbm_ack_i),
        .i_dat    (wbm_dat_i)
    );

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = BASE_ADDR + OFS_CTRL;
        w_wdata      = '0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_state_next = ST_WR_KLO;
            end
            ST_WR_KLO: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = BASE_ADDR + OFS_KEY_LO;
                w_wdata = r_key[31:0];
                if (w_done) w_state_next = ST_WR_KHI;
            end
            ST_WR_KHI: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = BASE_ADDR + OFS_KEY_HI;
                w_wdata = r_key[63:32];
                if (w_done) w_state_next = ST_WR_FRM;
            end
            ST_WR_FRM: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = BASE_ADDR + OFS_FRAME;
                w_wdata = {10'b0, r_frame};
                if (w_done) w_state_next = ST_WR_GO;
            end
            ST_WR_GO: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_addr  = BASE_ADDR + OFS_CTRL;
                w_wdata = 32'h1;
                if (w_done) w_state_next = ST_POLL;
            end
            ST_POLL: begin
                w_req  = 1'b1;
                w_addr = BASE_ADDR + OFS_STATUS;
                if (w_done && w_rdata[STATUS_READY_BIT]) w_state_next = ST_RD_KS;
            end
            ST_RD_KS: begin
                w_req  = 1'b1;
                w_addr = BASE_ADDR + OFS_KS;
                if (w_done) w_state_next = ST_PUSH;
            end
            ST_PUSH: begin
                // Launch the next KS read on the handshake edge itself so
                // each further word costs two cycles.
                if (ks_ready) begin
                    if (w_last) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_RD_KS;
                        w_req        = 1'b1;
                        w_addr       = BASE_ADDR + OFS_KS;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_timeout) w_state_next = ST_IDLE;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_key      <= '0;
            r_frame    <= '0;
            r_word_cnt <= '0;
            r_ks_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && cmd_valid) begin
                r_key      <= cmd_key;
                r_frame    <= cmd_frame;
                r_word_cnt <= '0;
            end
            if (r_state == ST_RD_KS && w_done) r_ks_data <= w_rdata;
            if (r_state == ST_PUSH && ks_ready) r_word_cnt <= r_word_cnt + 4'd1;
        end
    end

`ifdef A51_MASTER_TIMEOUT_EN
    logic r_err;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_err <= 1'b0;
        else          r_err <= w_timeout;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign ks_valid  = (r_state == ST_PUSH);
    assign ks_data   = r_ks_data;
    assign ks_last   = ks_valid && w_last;

endmodule

// File: tb/tb_a51_wb_master.sv
// Bench for a51_wb_master: behavioural Wishbone responder, protocol monitor
// and per-scenario tasks comparing against expected register sequences.
`timescale 1ns/1ps
module tb_a51_wb_master;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          WORDS = 4;
    localparam int          TMO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_key;
    logic [21:0] cmd_frame;
    logic        ks_valid;
    logic        ks_ready;
    logic [31:0] ks_data;
    logic        ks_last;
    logic        busy;
    logic        err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    always #5 clk = ~clk;

    a51_wb_master #(
        .BASE_ADDR(BASE),
        .WORDS(WORDS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_frame(cmd_frame),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_last(ks_last),
        .busy(busy), .err(err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- responder model ----------------
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    int          rsp_waits     = 0;
    int          rsp_not_ready = 0;
    bit          rsp_never_ack = 1'b0;
    int          status_base   = 0;
    int          wait_cnt      = 0;
    int          status_reads  = 0;
    int          ks_idx        = 0;
    logic [31:0] ks_mem [WORDS];
    txn_t        log_q [$];

    assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !rsp_never_ack && (wait_cnt >= rsp_waits);

    always_comb begin
        wbm_dat_i = 32'hDEAD_BEEF;
        if (wbm_adr_o == BASE + 32'h4)
            wbm_dat_i = ((status_reads - status_base) >= rsp_not_ready) ? 32'h1 : 32'hFFFF_FFFE;
        else if (wbm_adr_o == BASE + 32'h14)
            wbm_dat_i = ks_mem[ks_idx % WORDS];
    end

    always @(posedge clk) begin
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            log_q.push_back(txn_t'{wbm_we_o, wbm_adr_o, wbm_dat_o});
            wait_cnt <= 0;
            if (!wbm_we_o && wbm_adr_o == BASE + 32'h4)  status_reads <= status_reads + 1;
            if (!wbm_we_o && wbm_adr_o == BASE + 32'h14) ks_idx <= ks_idx + 1;
        end else if (wbm_cyc_o && wbm_stb_o) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // ---------------- protocol monitor ----------------
    int          prot_viol = 0;
    int          gap_viol  = 0;
    int          err_seen  = 0;
    logic        m_cyc     = 1'b0;
    logic        m_ack     = 1'b0;
    logic [68:0] m_snap    = '0;

    always @(negedge clk) begin
        prot_viol <= prot_viol
            + ((wbm_cyc_o && m_cyc && !m_ack &&
                {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} !== m_snap) ? 1 : 0)
            + ((wbm_cyc_o && (!wbm_stb_o || wbm_sel_o !== 4'hF)) ? 1 : 0);
        gap_viol  <= gap_viol + ((wbm_cyc_o && m_ack) ? 1 : 0);
        err_seen  <= err_seen + (err ? 1 : 0);
        m_cyc     <= wbm_cyc_o;
        m_ack     <= wbm_ack_i;
        m_snap    <= {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};
    end

    // ---------------- session driver (observation only) ----------------
    logic [31:0] got_data [$];
    logic        got_last [$];
    int          hs_cyc   [$];
    int          hs_cnt;
    int          first_valid_cyc;
    int          log_base;
    int          ks_base;
    bit          timed_out;
    bit          ready_after;
    int          stall_viol;

    task automatic do_session(input logic [63:0] key, input logic [21:0] frame,
                              input int stall_word, input int stall_len);
        int          stall_left = stall_len;
        int          guard      = 0;
        bit          stalling   = 1'b0;
        logic [31:0] held       = '0;
        got_data.delete();
        got_last.delete();
        hs_cyc.delete();
        for (int i = 0; i < WORDS; i++) ks_mem[i] = $urandom;
        log_base        = log_q.size();
        status_base     = status_reads;
        ks_base         = ks_idx;
        first_valid_cyc = -1;
        timed_out       = 1'b0;
        stall_viol      = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_key   = key;
        cmd_frame = frame;
        ks_ready  = 1'b1;
        @(negedge clk);
        hs_cnt    = cyc_cnt;
        cmd_valid = 1'b0;
        while (got_data.size() < WORDS) begin
            if (ks_valid && first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
            if (ks_valid && got_data.size() == stall_word && stall_left > 0) begin
                if (!stalling) held = ks_data;
                stalling = 1'b1;
                if (ks_data !== held || wbm_cyc_o) stall_viol++;
                ks_ready = 1'b0;
                stall_left--;
            end else begin
                ks_ready = 1'b1;
                if (ks_valid) begin
                    got_data.push_back(ks_data);
                    got_last.push_back(ks_last);
                    hs_cyc.push_back(cyc_cnt);
                end
            end
            @(negedge clk);
            guard++;
            if (guard > 3000) begin
                timed_out = 1'b1;
                break;
            end
        end
        ready_after = cmd_ready;
        ks_ready    = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        n_checks++;
        if ({busy, ks_valid, ks_last, err, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl_outputs: got %b expected 0000000",
                               {busy, ks_valid, ks_last, err, wbm_cyc_o, wbm_stb_o, wbm_we_o});
        end
        n_checks++;
        if ({wbm_sel_o, wbm_adr_o, wbm_dat_o, ks_data} !== 100'b0) begin
            n_fail++; $display("FAIL reset_data_outputs: sel=%h adr=%h dat=%h ks=%h expected all 0",
                               wbm_sel_o, wbm_adr_o, wbm_dat_o, ks_data);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: cmd_ready=%b busy=%b cyc=%b", cmd_ready, busy, wbm_cyc_o);
    endtask

    task automatic test_basic;
        logic [63:0] key   = 64'h1234_5678_9ABC_DEF0;
        logic [21:0] frame = 22'h134;
        txn_t        exp_q [$];
        int          g0    = gap_viol;
        rsp_waits     = 0;
        rsp_not_ready = 0;
        do_session(key, frame, -1, 0);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL basic_complete: got timeout expected 4 words"); end
        n_checks++;
        if (first_valid_cyc - hs_cnt !== 12) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected 12", first_valid_cyc - hs_cnt);
        end
        for (int i = 0; i < WORDS; i++) begin
            n_checks++;
            if (got_data[i] !== ks_mem[(ks_base + i) % WORDS] || got_last[i] !== (i == WORDS - 1)) begin
                n_fail++; $display("FAIL basic_word%0d: got %h last=%b expected %h last=%b",
                                   i, got_data[i], got_last[i], ks_mem[(ks_base + i) % WORDS], i == WORDS - 1);
            end
            if (i > 0) begin
                n_checks++;
                if (hs_cyc[i] - hs_cyc[i-1] !== 2) begin
                    n_fail++; $display("FAIL basic_spacing%0d: got %0d expected 2", i, hs_cyc[i] - hs_cyc[i-1]);
                end
            end
        end
        n_checks++;
        if (ready_after !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b expected 1", ready_after); end
        exp_q.push_back(txn_t'{1'b1, BASE + 32'h08, 32'h9ABC_DEF0});
        exp_q.push_back(txn_t'{1'b1, BASE + 32'h0C, 32'h1234_5678});
        exp_q.push_back(txn_t'{1'b1, BASE + 32'h10, 32'h0000_0134});
        exp_q.push_back(txn_t'{1'b1, BASE + 32'h00, 32'h0000_0001});
        exp_q.push_back(txn_t'{1'b0, BASE + 32'h04, 32'h0});
        for (int i = 0; i < WORDS; i++) exp_q.push_back(txn_t'{1'b0, BASE + 32'h14, 32'h0});
        n_checks++;
        if (log_q.size() - log_base !== exp_q.size()) begin
            n_fail++; $display("FAIL basic_txn_count: got %0d expected %0d", log_q.size() - log_base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            txn_t g = (log_base + i < log_q.size()) ? log_q[log_base + i] : '0;
            n_checks++;
            if (g.we !== exp_q[i].we || g.adr !== exp_q[i].adr || (exp_q[i].we && g.dat !== exp_q[i].dat)) begin
                n_fail++; $display("FAIL basic_txn%0d: got we=%b adr=%h dat=%h expected we=%b adr=%h dat=%h",
                                   i, g.we, g.adr, g.dat, exp_q[i].we, exp_q[i].adr, exp_q[i].dat);
            end
        end
        n_checks++;
        if (gap_viol - g0 !== 0) begin n_fail++; $display("FAIL basic_idle_gap: got %0d violations expected 0", gap_viol - g0); end
        $display("basic: %0d words latency=%0d txns=%0d", got_data.size(), first_valid_cyc - hs_cnt, log_q.size() - log_base);
    endtask

    task automatic test_poll;
        int n_status = 0;
        int g0       = gap_viol;
        rsp_waits     = 0;
        rsp_not_ready = 3;
        do_session({$urandom, $urandom}, 22'($urandom), -1, 0);
        for (int i = log_base; i < log_q.size(); i++)
            if (!log_q[i].we && log_q[i].adr == BASE + 32'h4) n_status++;
        n_checks++;
        if (n_status !== 4) begin n_fail++; $display("FAIL poll_status_reads: got %0d expected 4", n_status); end
        n_checks++;
        if (gap_viol - g0 !== 0) begin n_fail++; $display("FAIL poll_idle_gap: got %0d violations expected 0", gap_viol - g0); end
        for (int i = 0; i < WORDS; i++) begin
            n_checks++;
            if (got_data[i] !== ks_mem[(ks_base + i) % WORDS]) begin
                n_fail++; $display("FAIL poll_word%0d: got %h expected %h", i, got_data[i], ks_mem[(ks_base + i) % WORDS]);
            end
        end
        $display("poll: status_reads=%0d words=%0d", n_status, got_data.size());
        rsp_not_ready = 0;
    endtask

    task automatic test_wait_states;
        int p0 = prot_viol;
        rsp_waits     = 3;
        rsp_not_ready = 0;
        do_session({$urandom, $urandom}, 22'($urandom), -1, 0);
        n_checks++;
        if (prot_viol - p0 !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d violations expected 0", prot_viol - p0); end
        n_checks++;
        if (log_q.size() - log_base !== 5 + WORDS) begin
            n_fail++; $display("FAIL wait_txn_count: got %0d expected %0d", log_q.size() - log_base, 5 + WORDS);
        end
        for (int i = 0; i < WORDS; i++) begin
            n_checks++;
            if (got_data[i] !== ks_mem[(ks_base + i) % WORDS]) begin
                n_fail++; $display("FAIL wait_word%0d: got %h expected %h", i, got_data[i], ks_mem[(ks_base + i) % WORDS]);
            end
        end
        $display("wait_states: words=%0d txns=%0d", got_data.size(), log_q.size() - log_base);
        rsp_waits = 0;
    endtask

    task automatic test_back_pressure;
        rsp_waits = 0;
        do_session({$urandom, $urandom}, 22'($urandom), 1, 10);
        n_checks++;
        if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d violations expected 0", stall_viol); end
        for (int i = 0; i < WORDS; i++) begin
            n_checks++;
            if (got_data[i] !== ks_mem[(ks_base + i) % WORDS] || got_last[i] !== (i == WORDS - 1)) begin
                n_fail++; $display("FAIL stall_word%0d: got %h last=%b expected %h last=%b",
                                   i, got_data[i], got_last[i], ks_mem[(ks_base + i) % WORDS], i == WORDS - 1);
            end
        end
        $display("back_pressure: words=%0d stall_violations=%0d", got_data.size(), stall_viol);
    endtask

    task automatic test_reset_mid;
        bit          found = 1'b0;
        logic [63:0] key2  = {$urandom, $urandom};
        rsp_waits = 3;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_key   = {$urandom, $urandom};
        cmd_frame = 22'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (wbm_cyc_o && wbm_adr_o == BASE + 32'h10) found = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rstmid_reach_frame: got no FRAME cycle expected one"); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({wbm_cyc_o, cmd_ready, err, busy} !== 4'b0100) begin
            n_fail++; $display("FAIL rstmid_after: got cyc/ready/err/busy=%b expected 0100",
                               {wbm_cyc_o, cmd_ready, err, busy});
        end
        rst       = 1'b0;
        rsp_waits = 0;
        do_session(key2, 22'($urandom), -1, 0);
        n_checks++;
        if (log_q[log_base].dat !== key2[31:0]) begin
            n_fail++; $display("FAIL rstmid_new_key: got %h expected %h", log_q[log_base].dat, key2[31:0]);
        end
        for (int i = 0; i < WORDS; i++) begin
            n_checks++;
            if (got_data[i] !== ks_mem[(ks_base + i) % WORDS]) begin
                n_fail++; $display("FAIL rstmid_word%0d: got %h expected %h", i, got_data[i], ks_mem[(ks_base + i) % WORDS]);
            end
        end
        $display("reset_mid: recovered words=%0d", got_data.size());
    endtask

    task automatic test_random_sessions;
        int e0 = err_seen;
        for (int s = 0; s < 4; s++) begin
            logic [63:0] key   = {$urandom, $urandom};
            logic [21:0] frame = 22'($urandom);
            int          nr    = $urandom_range(0, 3);
            txn_t        exp_q [$];
            rsp_waits     = $urandom_range(0, 3);
            rsp_not_ready = nr;
            do_session(key, frame, $urandom_range(0, WORDS - 1), $urandom_range(0, 5));
            exp_q.push_back(txn_t'{1'b1, BASE + 32'h08, key[31:0]});
            exp_q.push_back(txn_t'{1'b1, BASE + 32'h0C, key[63:32]});
            exp_q.push_back(txn_t'{1'b1, BASE + 32'h10, {10'b0, frame}});
            exp_q.push_back(txn_t'{1'b1, BASE + 32'h00, 32'h1});
            for (int i = 0; i <= nr; i++) exp_q.push_back(txn_t'{1'b0, BASE + 32'h04, 32'h0});
            for (int i = 0; i < WORDS; i++) exp_q.push_back(txn_t'{1'b0, BASE + 32'h14, 32'h0});
            n_checks++;
            if (log_q.size() - log_base !== exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_txn_count: got %0d expected %0d", s, log_q.size() - log_base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                txn_t g = (log_base + i < log_q.size()) ? log_q[log_base + i] : '0;
                n_checks++;
                if (g.we !== exp_q[i].we || g.adr !== exp_q[i].adr || (exp_q[i].we && g.dat !== exp_q[i].dat)) begin
                    n_fail++; $display("FAIL rand%0d_txn%0d: got we=%b adr=%h dat=%h expected we=%b adr=%h dat=%h",
                                       s, i, g.we, g.adr, g.dat, exp_q[i].we, exp_q[i].adr, exp_q[i].dat);
                end
            end
            for (int i = 0; i < WORDS; i++) begin
                n_checks++;
                if (got_data[i] !== ks_mem[(ks_base + i) % WORDS] || got_last[i] !== (i == WORDS - 1)) begin
                    n_fail++; $display("FAIL rand%0d_word%0d: got %h last=%b expected %h last=%b", s, i,
                                       got_data[i], got_last[i], ks_mem[(ks_base + i) % WORDS], i == WORDS - 1);
                end
            end
            $display("random session %0d: waits=%0d not_ready=%0d words=%0d", s, rsp_waits, nr, got_data.size());
        end
        n_checks++;
        if (err_seen - e0 !== 0) begin n_fail++; $display("FAIL rand_no_err: got %0d err cycles expected 0", err_seen - e0); end
        rsp_waits     = 0;
        rsp_not_ready = 0;
    endtask

`ifdef A51_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        int hi      = 0;
        bit seen_hi = 1'b0;
        int e0      = err_seen;
        rsp_never_ack = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_key   = {$urandom, $urandom};
        cmd_frame = 22'($urandom);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wbm_cyc_o) begin
                hi++;
                seen_hi = 1'b1;
            end else if (seen_hi) begin
                break;
            end
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (hi !== TMO) begin n_fail++; $display("FAIL timeout_cyc_len: got %0d expected %0d", hi, TMO); end
        n_checks++;
        if (err_seen - e0 !== 1) begin n_fail++; $display("FAIL timeout_err_pulse: got %0d expected 1", err_seen - e0); end
        n_checks++;
        if ({cmd_ready, busy, wbm_cyc_o} !== 3'b100) begin
            n_fail++; $display("FAIL timeout_idle: got ready/busy/cyc=%b expected 100", {cmd_ready, busy, wbm_cyc_o});
        end
        $display("timeout: cyc_len=%0d err_cycles=%0d", hi, err_seen - e0);
        rsp_never_ack = 1'b0;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_key   = '0;
        cmd_frame = '0;
        ks_ready  = 1'b0;
        for (int i = 0; i < WORDS; i++) ks_mem[i] = '0;
        test_reset();
        test_basic();
        test_poll();
        test_wait_states();
        test_back_pressure();
        test_reset_mid();
        test_random_sessions();
`ifdef A51_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got no completion expected finish within 50000 cycles");
        $fatal(1, "simulation time limit reached");
    end

endmodule
